// File: rtl/memory_responder.sv
// Word-addressed RAM behind the MAR/MDR interface. Requests are captured in IDLE,
// completed after LATENCY edges, and acknowledged with Done until both strobes drop.
module memory_responder #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic [31:0]           Address,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  Done,
    output logic                  Error
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic                    op_rd_r;
    logic                    op_wr_r;
    logic                    range_err_r;
    logic                    mem_we_s;
    logic [DATA_WIDTH-1:0]   mem_r [0:DEPTH-1];

    // Write strobe for the array: only a clean, in-range, write-only request completes a write.
    always_comb begin
        mem_we_s = 1'b0;
        if ((state_r == ACCESS) && (cnt_r == 4'd0) && op_wr_r && !op_rd_r && !range_err_r) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; deliberately has no reset so contents survive clear.
    always_ff @(posedge Clock) begin
        if (mem_we_s) begin
            mem_r[addr_r] <= data_r;
        end
    end

    // Request/acknowledge FSM with registered Done, Error and Mdatain.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            data_r      <= {DATA_WIDTH{1'b0}};
            op_rd_r     <= 1'b0;
            op_wr_r     <= 1'b0;
            range_err_r <= 1'b0;
            Mdatain     <= {DATA_WIDTH{1'b0}};
            Done        <= 1'b0;
            Error       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    Done  <= 1'b0;
                    Error <= 1'b0;
                    if (Read || Write) begin
                        addr_r      <= Address[ADDR_WIDTH-1:0];
                        data_r      <= DataIn;
                        op_rd_r     <= Read;
                        op_wr_r     <= Write;
                        range_err_r <= (Address[31:ADDR_WIDTH] != {(32-ADDR_WIDTH){1'b0}});
                        cnt_r       <= CNT_LOAD;
                        state_r     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r <= ACK;
                        Done    <= 1'b1;
                        // Conflicting strobes leave Mdatain alone; an out-of-range read returns zero.
                        if (op_rd_r && op_wr_r) begin
                            Error <= 1'b1;
                        end else if (range_err_r) begin
                            Error <= 1'b1;
                            if (op_rd_r) begin
                                Mdatain <= {DATA_WIDTH{1'b0}};
                            end
                        end else begin
                            Error <= 1'b0;
                            if (op_rd_r) begin
                                Mdatain <= mem_r[addr_r];
                            end
                        end
                    end
                end
                ACK: begin
                    if (!Read && !Write) begin
                        state_r <= IDLE;
                        Done    <= 1'b0;
                        Error   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    Done    <= 1'b0;
                    Error   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Directed-vector bench for memory_responder with hand-computed expectations.
module tb_memory_responder;

    localparam int LAT = 2;

    logic        Clock;
    logic        clear;
    logic [31:0] Address;
    logic        Read;
    logic        Write;
    logic [31:0] DataIn;
    logic [31:0] Mdatain;
    logic        Done;
    logic        Error;

    int total;
    int bad;

    memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
        .Clock   (Clock),
        .clear   (clear),
        .Address (Address),
        .Read    (Read),
        .Write   (Write),
        .DataIn  (DataIn),
        .Mdatain (Mdatain),
        .Done    (Done),
        .Error   (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a request from just after an edge; check latency and Error. Strobes stay asserted.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic exp_err);
        Read = rd; Write = wr; Address = a; DataIn = d;
        @(posedge Clock); #1;
        Address = 32'h0000_0003; DataIn = 32'hFFFF_FFFF;
        for (int i = 1; i < LAT; i++) begin
            @(posedge Clock); #1;
            chk("done_early", {31'd0, Done}, 32'd0);
        end
        @(posedge Clock); #1;
        chk("done", {31'd0, Done}, 32'd1);
        chk("error", {31'd0, Error}, {31'd0, exp_err});
    endtask

    task automatic release_req();
        Read = 1'b0; Write = 1'b0;
        @(posedge Clock); #1;
        chk("done_rel", {31'd0, Done}, 32'd0);
        chk("err_rel", {31'd0, Error}, 32'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        clear = 1'b0; Read = 1'b0; Write = 1'b0;
        Address = 32'd0; DataIn = 32'd0;
        #2;
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_err", {31'd0, Error}, 32'd0);
        chk("rst_mdata", Mdatain, 32'd0);
        repeat (2) @(posedge Clock);
        #1 clear = 1'b1;
        @(posedge Clock); #1;

        // Write then read back
        access(1'b0, 1'b1, 32'd2, 32'h0000_0007, 1'b0);
        release_req();
        access(1'b1, 1'b0, 32'd2, 32'd0, 1'b0);
        chk("rd2", Mdatain, 32'h0000_0007);
        release_req();

        // Held read strobe: one access only
        access(1'b1, 1'b0, 32'd2, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge Clock); #1;
            chk("hold_done", {31'd0, Done}, 32'd1);
        end
        release_req();
        access(1'b0, 1'b1, 32'd2, 32'h0000_0055, 1'b0);
        chk("no_reread", Mdatain, 32'h0000_0007);
        release_req();

        // Both strobes rejected
        access(1'b0, 1'b1, 32'd3, 32'h0000_0033, 1'b0);
        release_req();
        access(1'b1, 1'b0, 32'd2, 32'd0, 1'b0);
        chk("rd2_new", Mdatain, 32'h0000_0055);
        release_req();
        access(1'b1, 1'b1, 32'd3, 32'hDEAD_BEEF, 1'b1);
        chk("both_mdata", Mdatain, 32'h0000_0055);
        release_req();
        access(1'b1, 1'b0, 32'd3, 32'd0, 1'b0);
        chk("rd3_kept", Mdatain, 32'h0000_0033);
        release_req();

        // Out of range
        access(1'b1, 1'b0, 32'h0000_0200, 32'd0, 1'b1);
        chk("oor_rd", Mdatain, 32'd0);
        release_req();
        access(1'b0, 1'b1, 32'd1, 32'h0000_0011, 1'b0);
        release_req();
        access(1'b0, 1'b1, 32'h0000_0201, 32'h0000_0018, 1'b1);
        release_req();
        access(1'b1, 1'b0, 32'd1, 32'd0, 1'b0);
        chk("rd1_kept", Mdatain, 32'h0000_0011);
        release_req();

        // Reset mid-access aborts the write
        access(1'b0, 1'b1, 32'd5, 32'h0000_00A5, 1'b0);
        release_req();
        Write = 1'b1; Address = 32'd5; DataIn = 32'h2091_8000;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        clear = 1'b0; Write = 1'b0;
        @(posedge Clock); #1;
        chk("abort_done", {31'd0, Done}, 32'd0);
        clear = 1'b1;
        @(posedge Clock); #1;
        chk("abort_done2", {31'd0, Done}, 32'd0);
        access(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
        chk("rd5_kept", Mdatain, 32'h0000_00A5);

        // Asynchronous clear while Done is high
        #3 clear = 1'b0;
        #1;
        chk("async_done", {31'd0, Done}, 32'd0);
        chk("async_err", {31'd0, Error}, 32'd0);
        chk("async_mdata", Mdatain, 32'd0);
        Read = 1'b0;
        @(posedge Clock); #1;
        clear = 1'b1;
        @(posedge Clock); #1;
        access(1'b1, 1'b0, 32'd1, 32'd0, 1'b0);
        chk("post_rst_rd", Mdatain, 32'h0000_0011);
        release_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Word-addressed RAM that sits on the memory side of the datapath's MAR/MDR interface.
- Answers the Read/Write strobes the control path raises, and returns read data on Mdatain to the MDR input mux.
- Uses a four-phase request/Done handshake with a programmable access latency, so the datapath can no longer assume data is present in the same cycle as Read.

Parameters:
- ADDR_WIDTH, 9, number of implemented word-address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- LATENCY, 2, rising edges from request capture to completion; legal range 1..15.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset, asynchronous, active-low.
- Address  in  32  word address from MAR.
- Read  in  1  read request strobe, level.
- Write  in  1  write request strobe, level.
- DataIn  in  DATA_WIDTH  write data from MDR.
- Mdatain  out  DATA_WIDTH  read data to MDR input mux; registered.
- Done  out  1  access complete acknowledge; registered.
- Error  out  1  request rejected; valid while Done=1; registered.

Behaviour:
- Reset (clear=0, any time, no clock needed):
  - state=IDLE, Done=0, Error=0, Mdatain=0, latency counter=0.
  - RAM contents are not cleared.
  - An in-flight write is aborted and leaves the RAM unchanged.
- State IDLE:
  - On an edge with Read|Write=1: latch Address, DataIn and operation; load cnt=LATENCY-1; go to ACCESS.
  - Strobes are sampled only in IDLE. Address and DataIn changes after capture are ignored.
- State ACCESS:
  - Each edge with cnt!=0: cnt decrements.
  - Edge with cnt==0: perform the operation and go to ACK. Done=1 is visible after this edge.
  - Latency: request sampled at edge k gives Done high after edge k+LATENCY.
- Operation rules, applied at completion:
  - Read only, Address[31:ADDR_WIDTH]==0: Mdatain <= RAM[Address[ADDR_WIDTH-1:0]]; Error=0.
  - Write only, upper bits ==0: RAM[addr] <= DataIn; Mdatain unchanged; Error=0.
  - Read and Write both 1 at capture: no RAM access; Mdatain unchanged; Error=1.
  - Upper address bits nonzero: no RAM write. A read returns Mdatain=0. Error=1.
- State ACK:
  - Done=1 and Error hold.
  - Edge with Read=0 and Write=0: go to IDLE; Done=0 and Error=0 after that edge.
  - Strobes still high: stay in ACK. A held strobe never re-issues an access.
- Mdatain holds its last read value until the next successful read completes, a rejected read (Error=1) completes, or reset.
- Minimum back-to-back spacing: request, LATENCY edges, one release edge, then a new capture on the next edge.
- No combinational path from any input to any output.

Test Plan:
- Reset values:
  - Drive clear=0 mid-cycle with Done high -> Done, Error and Mdatain go to 0 immediately, before the next edge.
  - Release clear -> state IDLE.
- Write then read, LATENCY=2:
  - Address=2, DataIn=32'h00000007, Write=1 captured at edge k -> Done=1 after edge k+2; Error=0.
  - Drop Write -> Done=0 after next edge.
  - Read of address 2 -> Mdatain=32'h00000007 with Done after 2 edges.
- Held strobe:
  - Keep Read=1 for 6 cycles after Done -> exactly one access, Done stays 1 throughout.
  - Change RAM[2] via another port-level write afterwards -> confirms no second read occurred.
- Both strobes:
  - Read=Write=1, Address=3, DataIn=32'hDEADBEEF -> Done with Error=1, RAM[3] unchanged on readback, Mdatain unchanged.
- Out of range:
  - Read at Address=32'h00000200 -> Done, Error=1, Mdatain=0.
  - Write 32'h18 to 32'h00000201 -> RAM[1] unchanged on readback.
- Reset mid-access:
  - Write 32'h20918000 to address 5, assert clear=0 one edge after capture -> Done never rises; readback of RAM[5] returns the prior value.
